if_id_hazard_ctrl: RTL and testbench

- Sequencing controller for the IF/ID pipeline register and PC of the 5-stage MIPS datapath.
- Decides each cycle whether PC and IF/ID advance, hold (stall) or flush (NOP insert), and whether ID/EX receives a bubble.
- Handles three hazard sources: load-use, taken branch/jump redirect, and instruction-memory wait.
- Keeps saturating performance counters of stall and flush cycles.

---
 rtl/if_id_hazard_ctrl_if.sv | 28 ++
 rtl/if_id_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_if_id_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_hazard_ctrl_if.sv
// Control/status bundle between the IF/ID hazard controller and the pipeline datapath.
// The master side owns the hazard inputs and the slave side owns the sequencing outputs.
interface if_id_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      ifid_instr;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic             redirect;
  logic             imem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ifid_instr, idex_memread, idex_rt, redirect, imem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_instr, idex_memread, idex_rt, redirect, imem_ready,
    output pc_write, ifid_write, ifid_flush, idex_bubble, busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// PC / IF/ID sequencing for the 5-stage MIPS pipe: load-use stall, redirect flush, imem wait.
// Control outputs decode state and inputs with zero latency; stall/flush counters saturate.
module if_id_hazard_ctrl #(
  parameter int unsigned BRANCH_PENALTY = 1,
  parameter int unsigned CNT_W          = 16
) (
  input logic               clk,
  input logic               reset_n,
  if_id_hazard_ctrl_if.slave bus
);
  localparam int unsigned PEN_W = 3;
  localparam logic [PEN_W-1:0] PEN_INIT = PEN_W'(BRANCH_PENALTY - 1);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, IMEM_WAIT} state_t;

  state_t           state_q, state_d;
  logic [PEN_W-1:0] pen_q, pen_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       uses_rt, lu;
  logic       pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;
  logic       unused_instr_bits;

  assign opcode  = bus.ifid_instr[31:26];
  assign rs      = bus.ifid_instr[25:21];
  assign rt      = bus.ifid_instr[20:16];
  assign uses_rt = opcode inside {6'd0, 6'd4, 6'd5, 6'd43};
  assign unused_instr_bits = ^bus.ifid_instr[15:0];

  // Load-use: the load's destination feeds a source of the instruction in ID
  assign lu = bus.idex_memread && (bus.idex_rt != 5'd0) &&
              ((bus.idex_rt == rs) || (uses_rt && (bus.idex_rt == rt)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      pen_q   <= '0;
    end else begin
      state_q <= state_d;
      pen_q   <= pen_d;
    end
  end

  // Next state and control decode; redirect overrides every state
  always_comb begin
    state_d       = state_q;
    pen_d         = pen_q;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    if (!reset_n) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      state_d       = RUN;
      pen_d         = '0;
    end else if (bus.redirect) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      if (BRANCH_PENALTY > 1) begin
        state_d = FLUSH;
        pen_d   = PEN_INIT;
      end else begin
        state_d = RUN;
        pen_d   = '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (lu) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
            state_d       = LU_STALL;
          end else if (!bus.imem_ready) begin
            pc_write_c    = 1'b0;
            ifid_flush_c  = 1'b1;
            state_d       = IMEM_WAIT;
          end
        end
        LU_STALL: begin
          pc_write_c    = 1'b0;
          ifid_write_c  = 1'b0;
          idex_bubble_c = 1'b1;
          state_d       = RUN;
        end
        FLUSH: begin
          pc_write_c    = bus.imem_ready;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          // Penalty only counts down on cycles that actually fetched
          if (bus.imem_ready) begin
            if (pen_q <= PEN_W'(1)) begin
              state_d = RUN;
              pen_d   = '0;
            end else begin
              pen_d   = pen_q - PEN_W'(1);
            end
          end
        end
        IMEM_WAIT: begin
          if (bus.imem_ready) begin
            state_d = RUN;
          end else begin
            pc_write_c   = 1'b0;
            ifid_flush_c = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_c && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (ifid_flush_c && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_write    = pc_write_c;
  assign bus.ifid_write  = ifid_write_c;
  assign bus.ifid_flush  = ifid_flush_c;
  assign bus.idex_bubble = idex_bubble_c;
  assign bus.busy        = reset_n && (state_q != RUN);
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Scoreboard bench for if_id_hazard_ctrl: directed hazard scenarios plus random traffic,
// checked against a behavioural model of the stall/flush rules.
module tb_if_id_hazard_ctrl;
  localparam int unsigned BP    = 2;
  localparam int unsigned CNT_W = 16;
  localparam int          MAXC  = (1 << CNT_W) - 1;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ADD  = 32'h010A_4820;                 // add $t1,$t0,$t2
  localparam logic [31:0] SW   = {6'd43, 5'd29, 5'd8, 16'h0004}; // sw $t0,4($sp)
  localparam logic [31:0] ADDI = {6'd8, 5'd9, 5'd8, 16'h0001};   // addi $t0,$t1,1

  typedef struct packed {
    logic             pc;
    logic             ifw;
    logic             fl;
    logic             bub;
    logic             busy;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  if_id_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  if_id_hazard_ctrl #(.BRANCH_PENALTY(BP), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model: pending obligations rather than an explicit state machine
  bit m_lu_owed;      // one more load-use stall cycle is owed
  int m_flush_left;   // extra flushing fetch cycles still owed after a redirect
  bit m_fetch_wait;   // waiting on instruction memory
  int m_sc, m_fc;

  function automatic bit load_use(input logic [31:0] instr, input bit mr, input logic [4:0] lrt);
    int op, src_s, src_t;
    bit reads_rt;
    op = int'(instr[31:26]);
    src_s = int'(instr[25:21]);
    src_t = int'(instr[20:16]);
    reads_rt = (op == 0) || (op == 4) || (op == 5) || (op == 43);
    return mr && (lrt != 0) && ((int'(lrt) == src_s) || (reads_rt && int'(lrt) == src_t));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Drive one cycle of inputs, predict the DUT response and advance the model past the edge
  task automatic cyc(input bit rst_n, input logic [31:0] instr, input bit mr,
                     input logic [4:0] lrt, input bit rd, input bit rdy);
    obs_t e;
    bit busy_now;
    @(negedge clk);
    reset_n          = rst_n;
    bus.ifid_instr   = instr;
    bus.idex_memread = mr;
    bus.idex_rt      = lrt;
    bus.redirect     = rd;
    bus.imem_ready   = rdy;
    #1;
    busy_now = m_lu_owed || (m_flush_left > 0) || m_fetch_wait;
    e.sc = CNT_W'(m_sc);
    e.fc = CNT_W'(m_fc);
    if (!rst_n) begin
      {e.pc, e.ifw, e.fl, e.bub, e.busy} = 5'b00110;
      m_lu_owed = 0; m_flush_left = 0; m_fetch_wait = 0; m_sc = 0; m_fc = 0;
    end else begin
      e.busy = busy_now;
      if (rd) begin
        {e.pc, e.ifw, e.fl, e.bub} = 4'b1111;
        m_lu_owed = 0; m_fetch_wait = 0; m_flush_left = int'(BP) - 1;
      end else if (m_flush_left > 0) begin
        {e.pc, e.ifw, e.fl, e.bub} = {rdy, 3'b111};
        if (rdy) m_flush_left--;
      end else if (m_lu_owed) begin
        {e.pc, e.ifw, e.fl, e.bub} = 4'b0001;
        m_lu_owed = 0;
      end else if (m_fetch_wait) begin
        if (rdy) begin
          {e.pc, e.ifw, e.fl, e.bub} = 4'b1100;
          m_fetch_wait = 0;
        end else begin
          {e.pc, e.ifw, e.fl, e.bub} = 4'b0110;
        end
      end else if (load_use(instr, mr, lrt)) begin
        {e.pc, e.ifw, e.fl, e.bub} = 4'b0001;
        m_lu_owed = 1;
      end else if (!rdy) begin
        {e.pc, e.ifw, e.fl, e.bub} = 4'b0110;
        m_fetch_wait = 1;
      end else begin
        {e.pc, e.ifw, e.fl, e.bub} = 4'b1100;
      end
      if (!e.pc && m_sc < MAXC) m_sc++;
      if (e.fl && m_fc < MAXC) m_fc++;
    end
    sb.push_back(e);
  endtask

  task automatic do_reset();
    repeat (3) cyc(1'b0, NOP, 1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b1, ADD, 1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  // Monitor: compare every presented cycle against the queued prediction
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble, bus.busy,
              bus.stall_cnt, bus.flush_cnt};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL scoreboard @%0t: actual pc=%b ifw=%b fl=%b bub=%b busy=%b sc=%0d fc=%0d required pc=%b ifw=%b fl=%b bub=%b busy=%b sc=%0d fc=%0d",
                      $time, a.pc, a.ifw, a.fl, a.bub, a.busy, a.sc, a.fc,
                      e.pc, e.ifw, e.fl, e.bub, e.busy, e.sc, e.fc);
      end
    end
  end

  initial begin
    logic [5:0] ops [6];
    ops = '{6'd0, 6'd4, 6'd5, 6'd43, 6'd8, 6'd35};
    bus.ifid_instr = NOP; bus.idex_memread = 0; bus.idex_rt = 0;
    bus.redirect = 0; bus.imem_ready = 1;
    repeat (2) @(posedge clk);

    do_reset();
    chk("rst_pc_write", bus.pc_write, 0);
    chk("rst_ifid_flush", bus.ifid_flush, 1);
    chk("rst_idex_bubble", bus.idex_bubble, 1);
    idle();
    chk("post_rst_pc_write", bus.pc_write, 1);
    chk("post_rst_ifid_write", bus.ifid_write, 1);
    chk("post_rst_stall_cnt", bus.stall_cnt, 0);
    chk("post_rst_flush_cnt", bus.flush_cnt, 0);

    // load-use on rs
    cyc(1, ADD, 1, 5'd8, 0, 1);
    chk("lu1_pc_write", bus.pc_write, 0);
    chk("lu1_ifid_write", bus.ifid_write, 0);
    chk("lu1_bubble", bus.idex_bubble, 1);
    cyc(1, ADD, 1, 5'd8, 0, 1);
    chk("lu2_pc_write", bus.pc_write, 0);
    chk("lu2_busy", bus.busy, 1);
    idle();
    chk("lu_done_pc_write", bus.pc_write, 1);
    chk("lu_stall_cnt", bus.stall_cnt, 2);
    cyc(1, ADD, 1, 5'd0, 0, 1);
    chk("lu_r0_pc_write", bus.pc_write, 1);
    cyc(1, SW, 1, 5'd8, 0, 1);
    chk("lu_sw_pc_write", bus.pc_write, 0);
    cyc(1, SW, 0, 5'd0, 0, 1);
    chk("lu_sw2_pc_write", bus.pc_write, 0);
    cyc(1, ADDI, 1, 5'd8, 0, 1);
    chk("lu_addi_pc_write", bus.pc_write, 1);

    // redirect with a two-cycle penalty
    do_reset();
    idle();
    cyc(1, ADD, 0, 5'd0, 1, 1);
    chk("rd1_flush", bus.ifid_flush, 1);
    chk("rd1_bubble", bus.idex_bubble, 1);
    chk("rd1_pc_write", bus.pc_write, 1);
    chk("rd1_busy", bus.busy, 0);
    idle();
    chk("rd2_flush", bus.ifid_flush, 1);
    chk("rd2_pc_write", bus.pc_write, 1);
    chk("rd2_busy", bus.busy, 1);
    idle();
    chk("rd_done_flush", bus.ifid_flush, 0);
    chk("rd_flush_cnt", bus.flush_cnt, 2);

    // redirect and load-use together: flush wins, no stall
    cyc(1, ADD, 1, 5'd8, 1, 1);
    chk("rdlu_flush", bus.ifid_flush, 1);
    chk("rdlu_pc_write", bus.pc_write, 1);
    cyc(1, ADD, 1, 5'd8, 0, 1);
    chk("rdlu2_flush", bus.ifid_flush, 1);
    chk("rdlu2_pc_write", bus.pc_write, 1);
    idle();
    chk("rdlu_done_pc_write", bus.pc_write, 1);

    // redirect during imem wait
    cyc(1, ADD, 0, 5'd0, 0, 0);
    chk("wait_pc_write", bus.pc_write, 0);
    chk("wait_flush", bus.ifid_flush, 1);
    chk("wait_bubble", bus.idex_bubble, 0);
    cyc(1, ADD, 0, 5'd0, 1, 0);
    chk("wait_rd_pc_write", bus.pc_write, 1);
    cyc(1, ADD, 0, 5'd0, 0, 0);
    chk("wait_fl_pc_write", bus.pc_write, 0);
    chk("wait_fl_busy", bus.busy, 1);
    cyc(1, ADD, 0, 5'd0, 0, 1);
    chk("wait_fl_rdy_pc_write", bus.pc_write, 1);
    idle();
    chk("wait_done_busy", bus.busy, 0);

    // reset in the middle of a flush
    cyc(1, ADD, 0, 5'd0, 1, 1);
    cyc(0, ADD, 0, 5'd0, 0, 1);
    idle();
    chk("rstfl_busy", bus.busy, 0);
    chk("rstfl_flush", bus.ifid_flush, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] instr;
      instr = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 16'($urandom)};
      cyc(($urandom_range(0, 49) != 0), instr, ($urandom_range(0, 9) < 3),
          5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 8));
    end

    // counter saturation
    do_reset();
    repeat (70000) cyc(1, ADD, 0, 5'd0, 0, 0);
    chk("sat_stall_cnt", bus.stall_cnt, 32'h0000_FFFF);
    cyc(1, ADD, 0, 5'd0, 0, 0);
    chk("sat_stall_hold", bus.stall_cnt, 32'h0000_FFFF);
    chk("sat_flush_cnt", bus.flush_cnt, 32'h0000_FFFF);

    @(negedge clk);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
